// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the two-port memory arbiter.
// The arbiter uses the slave modport; the environment driving requests and the memory uses master.
interface mem_arbiter_if;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic [DATA_W-1:0] rdata0;
    logic              rvalid0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic [DATA_W-1:0] rdata1;
    logic              rvalid1;

    logic [ADDR_W-1:0] mem_addra;
    logic [DATA_W-1:0] mem_dina;
    logic              mem_wea;
    logic              mem_ena;
    logic              mem_getvalue;
    logic [DATA_W-1:0] mem_douta;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_douta,
        output gnt0, rdata0, rvalid0,
        output gnt1, rdata1, rvalid1,
        output mem_addra, mem_dina, mem_wea, mem_ena, mem_getvalue
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_douta,
        input  gnt0, rdata0, rvalid0,
        input  gnt1, rdata1, rvalid1,
        input  mem_addra, mem_dina, mem_wea, mem_ena, mem_getvalue
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port single-beat memory arbiter: round-robin on ties, bounded burst tenure while contended,
// unlimited tenure when uncontended. Grants are combinational; read data is registered.
module mem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clka,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

    state_e            state_q, state_d;
    logic              lsp_q, lsp_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic [31:0]       rdata0_q, rdata1_q;
    logic              rvalid0_q, rvalid1_q;

    logic own_k, req_own, req_oth;
    logic enter, enter_tgt;
    logic gnt0, gnt1, any_gnt;

    // Grants are gated by rst_n so a beat in a reset cycle is aborted.
    assign gnt0    = rst_n && (state_q == OWN0) && bus.req0;
    assign gnt1    = rst_n && (state_q == OWN1) && bus.req1;
    assign any_gnt = gnt0 | gnt1;

    assign own_k   = (state_q == OWN1);
    assign req_own = own_k ? bus.req1 : bus.req0;
    assign req_oth = own_k ? bus.req0 : bus.req1;

    always_ff @(posedge clka) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lsp_q     <= 1'b1;
            bcnt_q    <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lsp_q     <= lsp_d;
            bcnt_q    <= bcnt_d;
            rvalid0_q <= gnt0 & ~bus.we0;
            rvalid1_q <= gnt1 & ~bus.we1;
            if (gnt0 && !bus.we0) rdata0_q <= bus.mem_douta;
            if (gnt1 && !bus.we1) rdata1_q <= bus.mem_douta;
        end
    end

    always_comb begin
        state_d   = state_q;
        lsp_d     = lsp_q;
        bcnt_d    = bcnt_q;
        enter     = 1'b0;
        enter_tgt = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    enter     = 1'b1;
                    enter_tgt = ~lsp_q;
                end else if (bus.req0 || bus.req1) begin
                    enter     = 1'b1;
                    enter_tgt = bus.req1;
                end
            end
            OWN0, OWN1: begin
                if (!req_own) begin
                    if (req_oth) begin
                        enter     = 1'b1;
                        enter_tgt = ~own_k;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bcnt_q == BCNT_LAST) begin
                    // Burst limit only forces a handover if the other side is waiting.
                    if (req_oth) begin
                        enter     = 1'b1;
                        enter_tgt = ~own_k;
                    end else begin
                        bcnt_d = '0;
                    end
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter) begin
            state_d = enter_tgt ? OWN1 : OWN0;
            lsp_d   = enter_tgt;
            bcnt_d  = '0;
        end
    end

    // Idle memory port is driven to zeros with getvalue set, freezing content.
    always_comb begin
        bus.mem_addra = '0;
        bus.mem_dina  = '0;
        bus.mem_wea   = 1'b0;
        if (gnt0) begin
            bus.mem_addra = bus.addr0;
            bus.mem_dina  = bus.wdata0;
            bus.mem_wea   = bus.we0;
        end else if (gnt1) begin
            bus.mem_addra = bus.addr1;
            bus.mem_dina  = bus.wdata1;
            bus.mem_wea   = bus.we1;
        end
    end

    assign bus.mem_ena      = any_gnt;
    assign bus.mem_getvalue = ~any_gnt;
    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.rdata0       = rdata0_q;
    assign bus.rdata1       = rdata1_q;
    assign bus.rvalid0      = rvalid0_q;
    assign bus.rvalid1      = rvalid1_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (MAX_BURST=4) with a small behavioural memory on the memory port.
module tb_mem_arbiter;
    logic clka = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clka = ~clka;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_BURST(4)) dut (
        .clka  (clka),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory model: combinational read, write on edge only when enabled and not frozen.
    logic [31:0] mem [64];
    assign bus.mem_douta = mem[bus.mem_addra];
    always @(posedge clka) begin
        if (bus.mem_ena && bus.mem_wea && !bus.mem_getvalue)
            mem[bus.mem_addra] <= bus.mem_dina;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] gnts();
        return {30'd0, bus.gnt0, bus.gnt1};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd0; bus.wdata0 = 32'h0;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 6'd0; bus.wdata1 = 32'h0;
        step();
        step();
        settle();
        check("rst_gnt", gnts(), 32'd0);
        check("rst_ena", 32'(bus.mem_ena), 32'd0);
        check("rst_wea", 32'(bus.mem_wea), 32'd0);
        check("rst_getvalue", 32'(bus.mem_getvalue), 32'd1);
        check("rst_rvalid", {30'd0, bus.rvalid0, bus.rvalid1}, 32'd0);
        check("rst_rdata0", bus.rdata0, 32'd0);
        check("rst_rdata1", bus.rdata1, 32'd0);

        // Single write then read on port 0.
        rst_n = 1'b1;
        bus.req1 = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd5; bus.wdata0 = 32'hDEADBEEF;
        settle();
        check("first_grant_latency", gnts(), 32'd0);
        step(); settle();
        check("wr_gnt", gnts(), 32'd2);
        check("wr_addra", 32'(bus.mem_addra), 32'd5);
        check("wr_dina", bus.mem_dina, 32'hDEADBEEF);
        check("wr_wea", 32'(bus.mem_wea), 32'd1);
        check("wr_getvalue", 32'(bus.mem_getvalue), 32'd0);
        step();
        bus.we0 = 1'b0;
        settle();
        check("rd_gnt", gnts(), 32'd2);
        check("rd_wea", 32'(bus.mem_wea), 32'd0);
        step();
        bus.req0 = 1'b0;
        settle();
        check("rd_rvalid", 32'(bus.rvalid0), 32'd1);
        check("rd_rdata", bus.rdata0, 32'hDEADBEEF);
        step(); settle();
        check("rd_rvalid_pulse", 32'(bus.rvalid0), 32'd0);
        check("rd_rdata_hold", bus.rdata0, 32'hDEADBEEF);

        // Write addr 3 and addr 7, then idle with garbage on the ignored port.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd3; bus.wdata0 = 32'h12345678;
        step();
        step();
        bus.addr0 = 6'd7; bus.wdata0 = 32'h77777777;
        step();
        bus.req0 = 1'b0; bus.addr0 = 6'd3; bus.wdata0 = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("frz_getvalue", 32'(bus.mem_getvalue), 32'd1);
            check("frz_wea", 32'(bus.mem_wea), 32'd0);
            check("frz_addra", 32'(bus.mem_addra), 32'd0);
            step();
        end
        bus.req0 = 1'b1; bus.we0 = 1'b0;
        step(); settle();
        check("frz_rd_gnt", gnts(), 32'd2);
        step();
        bus.req0 = 1'b0;
        settle();
        check("frz_rd_rvalid", 32'(bus.rvalid0), 32'd1);
        check("frz_rd_data", bus.rdata0, 32'h12345678);
        step();

        // Uncontended burst of 10 beats: bcnt wraps, no switch.
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd5;
        step();
        for (int i = 0; i < 10; i++) begin
            settle();
            check($sformatf("unc_beat%0d", i), gnts(), 32'd2);
            step();
        end
        bus.req0 = 1'b0;
        settle();
        check("unc_release", gnts(), 32'd0);
        step();

        // Tie after reset: port 0 gets 4 beats, then port 1 with no gap.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = 6'd5; bus.addr1 = 6'd3;
        settle();
        check("tie_idle", gnts(), 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            settle();
            check($sformatf("tie_p0_beat%0d", i), gnts(), 32'd2);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            settle();
            check($sformatf("tie_p1_beat%0d", i), gnts(), 32'd1);
            step();
        end

        // Early release by port 1 hands over to port 0 with lsp=0.
        bus.req1 = 1'b0;
        settle();
        check("rel_no_beat", gnts(), 32'd0);
        step(); settle();
        check("rel_own0", gnts(), 32'd2);
        step();
        bus.req0 = 1'b0;
        settle();
        check("rel_drop", gnts(), 32'd0);
        step();
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        settle();
        check("lsp_idle", gnts(), 32'd0);
        step(); settle();
        check("lsp0_tie_to_p1", gnts(), 32'd1);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();
        step();

        // Reset asserted during a port-0 write beat to addr 7.
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 6'd7; bus.wdata0 = 32'hBAD0BAD0;
        step();
        rst_n = 1'b0;
        settle();
        check("mrst_gnt", gnts(), 32'd0);
        check("mrst_ena", 32'(bus.mem_ena), 32'd0);
        check("mrst_wea", 32'(bus.mem_wea), 32'd0);
        check("mrst_getvalue", 32'(bus.mem_getvalue), 32'd1);
        step(); settle();
        check("mrst_mem7", mem[7], 32'h77777777);
        check("mrst_rvalid", {30'd0, bus.rvalid0, bus.rvalid1}, 32'd0);
        check("mrst_rdata0", bus.rdata0, 32'd0);
        check("mrst_rdata1", bus.rdata1, 32'd0);
        rst_n = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd7;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 6'd5;
        settle();
        check("mrst_tie_idle", gnts(), 32'd0);
        step(); settle();
        check("mrst_tie_p0", gnts(), 32'd2);
        step();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        settle();
        check("mrst_rd_rvalid", 32'(bus.rvalid0), 32'd1);
        check("mrst_rd_data", bus.rdata0, 32'h77777777);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
